// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the single-pin interrupt controller and its
// dispatch master: register map, MER enable value, dispatch FSM states
// and the source-ID width helper.
package int_ctrl_pkg;

  localparam int unsigned ADDR_MER = 0;
  localparam int unsigned ADDR_IER = 1;
  localparam int unsigned ADDR_IAR = 2;
  localparam int unsigned ADDR_IPR = 3;

  // Master enable + hardware interrupt enable.
  localparam logic [1:0] MER_EN = 2'b11;

  typedef enum logic [2:0] {
    S_INIT_IER,
    S_INIT_MER,
    S_IDLE,
    S_WR_IER,
    S_RD_IPR,
    S_WR_IAR,
    S_PRESENT
  } state_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder over the pending-source vector.
// Ports:
//   req    in   N     pending sources
//   onehot out  N     one-hot of the lowest set bit (zero if none)
//   id     out  IDW   index of the lowest set bit (zero if none)
//   valid  out  1     any bit of req set
module int_prio_enc #(
  parameter int unsigned N   = 3,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] id,
  output logic           valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    onehot = '0;
    id     = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        id        = IDW'(i);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/int_dispatch_master.sv
// Wishbone initiator that programs the interrupt controller after reset and
// then turns each int_i assertion into an IPR read, an IAR acknowledge write
// and a vectored-IRQ handshake towards the CPU.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   int_i                      controller interrupt output
//   m_*                        wishbone master port (registered outputs)
//   ier_wr_i, ier_dat_i        request an IER rewrite with a new mask
//   irq_valid_o/id_o/ready_i   vector handshake to the CPU
//   spurious_o                 one-cycle pulse when IPR reads back empty
//   err_o                      sticky bus error / timeout flag
//
// state       | meaning
// S_INIT_IER  | writing IER_INIT to IER
// S_INIT_MER  | writing MER_EN to MER
// S_IDLE      | waiting for an IER rewrite request or int_i
// S_WR_IER    | writing the captured IER mask
// S_RD_IPR    | reading the pending register
// S_WR_IAR    | acknowledging the selected source
// S_PRESENT   | vector held until the CPU accepts it
module int_dispatch_master
  import int_ctrl_pkg::*;
#(
  parameter int unsigned         INT_NUM  = 3,
  parameter int unsigned         Dw       = 32,
  parameter int unsigned         Aw       = 3,
  parameter int unsigned         SELw     = 4,
  parameter logic [INT_NUM-1:0]  IER_INIT = '1,
  parameter int unsigned         TMO      = 255,
  localparam int unsigned        IDw      = id_width(INT_NUM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               int_i,
  output logic [Dw-1:0]      m_dat_o,
  output logic [SELw-1:0]    m_sel_o,
  output logic [Aw-1:0]      m_addr_o,
  output logic               m_stb_o,
  output logic               m_cyc_o,
  output logic               m_we_o,
  input  logic [Dw-1:0]      m_dat_i,
  input  logic               m_ack_i,
  input  logic               m_err_i,
  input  logic               m_rty_i,
  input  logic               ier_wr_i,
  input  logic [INT_NUM-1:0] ier_dat_i,
  output logic               irq_valid_o,
  output logic [IDw-1:0]     irq_id_o,
  input  logic               irq_ready_i,
  output logic               spurious_o,
  output logic               err_o
);

  localparam logic [7:0] TMO_LD = 8'(TMO - 1);

  state_t               state_q, state_d;
  logic                 stb_q, stb_d;
  logic                 we_q, we_d;
  logic [Aw-1:0]        addr_q, addr_d;
  logic [Dw-1:0]        dat_q, dat_d;
  logic [7:0]           tmo_q, tmo_d;
  logic                 ier_pend_q, ier_pend_d;
  logic [INT_NUM-1:0]   ier_val_q, ier_val_d;
  logic [INT_NUM-1:0]   sel_oh_q, sel_oh_d;
  logic [IDw-1:0]       sel_id_q, sel_id_d;
  logic                 valid_q, valid_d;
  logic [IDw-1:0]       id_q, id_d;
  logic                 spur_q, spur_d;
  logic                 err_q, err_d;

  logic [INT_NUM-1:0]   enc_oh;
  logic [IDw-1:0]       enc_id;
  logic                 enc_valid;

  int_prio_enc #(.N(INT_NUM), .IDW(IDw)) u_enc (
    .req    (m_dat_i[INT_NUM-1:0]),
    .onehot (enc_oh),
    .id     (enc_id),
    .valid  (enc_valid)
  );

  if (Dw > INT_NUM) begin : g_dat_hi
    logic unused_dat_hi;
    assign unused_dat_hi = ^m_dat_i[Dw-1:INT_NUM];
  end

  // Per-state bus access; acc_init lets init steps advance even on error.
  logic [Aw-1:0] acc_addr;
  logic          acc_we;
  logic [Dw-1:0] acc_dat;
  state_t        acc_next;
  logic          acc_init;

  always_comb begin
    acc_addr = '0;
    acc_we   = 1'b1;
    acc_dat  = '0;
    acc_next = S_IDLE;
    acc_init = 1'b0;
    case (state_q)
      S_INIT_IER: begin
        acc_addr = Aw'(ADDR_IER);
        acc_dat  = Dw'(IER_INIT);
        acc_next = S_INIT_MER;
        acc_init = 1'b1;
      end
      S_INIT_MER: begin
        acc_addr = Aw'(ADDR_MER);
        acc_dat  = Dw'(MER_EN);
        acc_init = 1'b1;
      end
      S_WR_IER: begin
        acc_addr = Aw'(ADDR_IER);
        acc_dat  = Dw'(ier_val_q);
      end
      S_RD_IPR: begin
        acc_addr = Aw'(ADDR_IPR);
        acc_we   = 1'b0;
        acc_next = S_WR_IAR;
      end
      S_WR_IAR: begin
        acc_addr = Aw'(ADDR_IAR);
        acc_dat  = Dw'(sel_oh_q);
        acc_next = S_PRESENT;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    tmo_d      = tmo_q;
    ier_pend_d = ier_pend_q;
    ier_val_d  = ier_val_q;
    sel_oh_d   = sel_oh_q;
    sel_id_d   = sel_id_q;
    valid_d    = valid_q;
    id_d       = id_q;
    spur_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (ier_pend_q) begin
          ier_pend_d = 1'b0;
          state_d    = S_WR_IER;
        end else if (int_i) begin
          state_d = S_RD_IPR;
        end
      end
      S_PRESENT: begin
        if (irq_ready_i) begin
          valid_d = 1'b0;
          id_d    = '0;
          state_d = S_IDLE;
        end
      end
      S_INIT_IER, S_INIT_MER, S_WR_IER, S_RD_IPR, S_WR_IAR: begin
        // stb low on entry is the mandatory idle gap between bus cycles.
        if (!stb_q) begin
          stb_d  = 1'b1;
          addr_d = acc_addr;
          we_d   = acc_we;
          dat_d  = acc_dat;
          tmo_d  = TMO_LD;
        end else if (m_ack_i) begin
          stb_d   = 1'b0;
          state_d = acc_next;
          if (state_q == S_RD_IPR) begin
            sel_oh_d = enc_oh;
            sel_id_d = enc_id;
            if (!enc_valid) begin
              spur_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else if (state_q == S_WR_IAR) begin
            valid_d = 1'b1;
            id_d    = sel_id_q;
          end
        end else if (m_err_i) begin
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = acc_init ? acc_next : S_IDLE;
        end else if (m_rty_i) begin
          // Reissue after one low cycle; the timer reloads on reissue.
          stb_d = 1'b0;
        end else if (tmo_q == 8'd0) begin
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = acc_init ? acc_next : S_IDLE;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new request always wins over the clear on S_WR_IER entry.
    if (ier_wr_i) begin
      ier_pend_d = 1'b1;
      ier_val_d  = ier_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT_IER;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      tmo_q      <= '0;
      ier_pend_q <= 1'b0;
      ier_val_q  <= '0;
      sel_oh_q   <= '0;
      sel_id_q   <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      spur_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      tmo_q      <= tmo_d;
      ier_pend_q <= ier_pend_d;
      ier_val_q  <= ier_val_d;
      sel_oh_q   <= sel_oh_d;
      sel_id_q   <= sel_id_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      spur_q     <= spur_d;
      err_q      <= err_d;
    end
  end

  assign m_stb_o     = stb_q;
  assign m_cyc_o     = stb_q;
  assign m_sel_o     = {SELw{stb_q}};
  assign m_we_o      = we_q;
  assign m_addr_o    = addr_q;
  assign m_dat_o     = dat_q;
  assign irq_valid_o = valid_q;
  assign irq_id_o    = id_q;
  assign spurious_o  = spur_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_int_dispatch_master.sv
// Directed bench: int_dispatch_master against a behavioural interrupt
// controller with stall / retry / forced-int hooks.
module tb_int_dispatch_master;
  import int_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_i;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic [2:0]  m_addr_o;
  logic        m_stb_o, m_cyc_o, m_we_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i, m_err_i, m_rty_i;
  logic        ier_wr_i;
  logic [2:0]  ier_dat_i;
  logic        irq_valid_o;
  logic [1:0]  irq_id_o;
  logic        irq_ready_i;
  logic        spurious_o, err_o;

  always #5 clk = ~clk;

  int_dispatch_master dut (
    .clk(clk), .reset(reset), .int_i(int_i),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_addr_o(m_addr_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_we_o(m_we_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i),
    .ier_wr_i(ier_wr_i), .ier_dat_i(ier_dat_i),
    .irq_valid_o(irq_valid_o), .irq_id_o(irq_id_o), .irq_ready_i(irq_ready_i),
    .spurious_o(spurious_o), .err_o(err_o)
  );

  // Controller model and shim controls
  logic [1:0] mer;
  logic [2:0] ier, ipr;
  logic [2:0] src_set;
  logic       force_int, stall_ipr, rty_arm;
  int         rty_cnt = 0;

  logic [2:0]  tr_addr[$];
  logic        tr_we[$];
  logic [31:0] tr_dat[$];

  assign m_err_i = 1'b0;
  assign int_i   = ((mer == 2'b11) && |(ipr & ier)) || force_int;

  always @(posedge clk) begin
    logic [2:0] ipr_n;
    if (reset) begin
      mer <= '0; ier <= '0; ipr <= '0;
      m_ack_i <= 1'b0; m_rty_i <= 1'b0; m_dat_i <= '0;
    end else begin
      m_ack_i <= 1'b0;
      m_rty_i <= 1'b0;
      ipr_n = ipr;
      if (m_stb_o && !m_ack_i && !m_rty_i &&
          !(stall_ipr && !m_we_o && m_addr_o == 3'd3)) begin
        if (rty_arm && rty_cnt == 0 && m_we_o && m_addr_o == 3'd2) begin
          m_rty_i <= 1'b1;
          rty_cnt <= rty_cnt + 1;
        end else begin
          m_ack_i <= 1'b1;
          tr_addr.push_back(m_addr_o);
          tr_we.push_back(m_we_o);
          if (m_we_o) begin
            tr_dat.push_back(m_dat_o);
            case (m_addr_o)
              3'd0: mer <= m_dat_o[1:0];
              3'd1: ier <= m_dat_o[2:0];
              3'd2: ipr_n = ipr & ~m_dat_o[2:0];
              default: ;
            endcase
          end else begin
            tr_dat.push_back({29'b0, ipr});
            // Junk above bit 2 must be ignored by the master.
            m_dat_i <= 32'hDEAD_BEE8 | {29'b0, ipr};
          end
        end
      end
      ipr <= ipr_n | src_set;
    end
  end

  // Monitor: stb rising edges, protocol invariants, pulse counters
  int          cyc = 0;
  logic        stb_prev = 1'b0;
  int          sel_bad = 0, id_bad = 0, spur_cnt = 0, valid_cnt = 0;
  int          rs_cyc[$];
  logic [2:0]  rs_addr[$];
  logic [31:0] rs_dat[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (m_stb_o && !stb_prev) begin
      rs_cyc.push_back(cyc);
      rs_addr.push_back(m_addr_o);
      rs_dat.push_back(m_dat_o);
    end
    stb_prev = m_stb_o;
    if (m_stb_o && m_sel_o != 4'hF) sel_bad++;
    if (m_cyc_o !== m_stb_o) sel_bad++;
    if (!irq_valid_o && irq_id_o != 2'd0) id_bad++;
    if (spurious_o) spur_cnt++;
    if (irq_valid_o) valid_cnt++;
  end

  int n_chk = 0, n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic we, input logic [2:0] a, input logic [31:0] d);
    return {28'b0, we, a, d};
  endfunction

  function automatic logic [63:0] tr_word(input int i);
    if (i >= tr_addr.size()) return '1;
    return {28'b0, tr_we[i], tr_addr[i], tr_dat[i]};
  endfunction

  task automatic clear_log();
    tr_addr.delete(); tr_we.delete(); tr_dat.delete();
    rs_cyc.delete(); rs_addr.delete(); rs_dat.delete();
  endtask

  task automatic pulse_src(input logic [2:0] v);
    src_set = v;
    @(negedge clk);
    src_set = 3'b000;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!irq_valid_o && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_ipr_stb(input int budget);
    int k = 0;
    while (!(m_stb_o && m_addr_o == 3'd3) && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  int   n, iar_rises, iar_first, iar_last, iar_wr;
  logic stable;

  initial begin
    reset = 1'b1; src_set = '0; force_int = 1'b0; stall_ipr = 1'b0; rty_arm = 1'b0;
    ier_wr_i = 1'b0; ier_dat_i = '0; irq_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ctl", {m_stb_o, m_cyc_o, m_we_o, irq_valid_o, spurious_o, err_o, irq_id_o}, 0);
    check_val("rst_bus", {m_addr_o, m_dat_o}, 0);

    // 1. init sequence
    clear_log();
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_val("init_cnt", tr_addr.size(), 2);
    check_val("init_ier", tr_word(0), mk(1'b1, 3'd1, 32'h7));
    check_val("init_mer", tr_word(1), mk(1'b1, 3'd0, 32'h3));
    check_val("init_idle", {m_stb_o, err_o}, 0);

    // 2. single source 1, ready held high
    clear_log();
    irq_ready_i = 1'b1;
    pulse_src(3'b010);
    wait_valid(20, n);
    check_val("t2_latency", n, 7);
    check_val("t2_vec", {irq_valid_o, irq_id_o}, {1'b1, 2'd1});
    @(negedge clk);
    check_val("t2_vlen", irq_valid_o, 0);
    check_val("t2_rd", tr_word(0), mk(1'b0, 3'd3, 32'h2));
    check_val("t2_iar", tr_word(1), mk(1'b1, 3'd2, 32'h2));
    check_val("t2_int_clr", int_i, 0);

    // 3. sources 0 and 2 together, ready delayed
    clear_log();
    irq_ready_i = 1'b0;
    pulse_src(3'b101);
    wait_valid(20, n);
    check_val("t3_vec0", {irq_valid_o, irq_id_o}, {1'b1, 2'd0});
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(irq_valid_o && irq_id_o == 2'd0)) stable = 1'b0;
    end
    check_val("t3_stable", stable, 1);
    irq_ready_i = 1'b1;
    @(negedge clk);
    irq_ready_i = 1'b0;
    check_val("t3_drop0", irq_valid_o, 0);
    wait_valid(20, n);
    check_val("t3_vec2", {irq_valid_o, irq_id_o}, {1'b1, 2'd2});
    irq_ready_i = 1'b1;
    @(negedge clk);
    irq_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_val("t3_cnt", tr_addr.size(), 4);
    check_val("t3_rd0", tr_word(0), mk(1'b0, 3'd3, 32'h5));
    check_val("t3_iar0", tr_word(1), mk(1'b1, 3'd2, 32'h1));
    check_val("t3_rd1", tr_word(2), mk(1'b0, 3'd3, 32'h4));
    check_val("t3_iar1", tr_word(3), mk(1'b1, 3'd2, 32'h4));

    // 4. spurious: int forced, IPR empty (upper junk bits set)
    clear_log();
    spur_cnt = 0; valid_cnt = 0;
    force_int = 1'b1;
    n = 0;
    while (!spurious_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    force_int = 1'b0;
    repeat (15) @(negedge clk);
    check_val("t4_spur", spur_cnt, 1);
    check_val("t4_novalid", valid_cnt, 0);
    check_val("t4_cnt", tr_addr.size(), 1);
    check_val("t4_rd", tr_word(0), mk(1'b0, 3'd3, 32'h0));

    // 5. IPR read timeout, then one retry on the IAR write
    clear_log();
    irq_ready_i = 1'b1; stall_ipr = 1'b1; rty_arm = 1'b1;
    pulse_src(3'b010);
    wait_ipr_stb(20);
    n = 0;
    while (m_stb_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("t5_hold", n, 255);
    check_val("t5_err", err_o, 1);
    check_val("t5_idle", dut.state_q, S_IDLE);
    stall_ipr = 1'b0;
    wait_valid(30, n);
    check_val("t5_vec", {irq_valid_o, irq_id_o}, {1'b1, 2'd1});
    repeat (3) @(negedge clk);
    check_val("t5_rty", rty_cnt, 1);
    iar_rises = 0; iar_first = 0; iar_last = 0;
    for (int i = 0; i < rs_addr.size(); i++) begin
      if (rs_addr[i] == 3'd2) begin
        if (rs_dat[i] != 32'h2) iar_rises += 100;
        if (iar_rises == 0) iar_first = rs_cyc[i];
        iar_last = rs_cyc[i];
        iar_rises++;
      end
    end
    check_val("t5_iar_issues", iar_rises, 2);
    check_val("t5_iar_gap", iar_last - iar_first, 3);
    iar_wr = 0;
    for (int i = 0; i < tr_addr.size(); i++)
      if (tr_we[i] && tr_addr[i] == 3'd2) iar_wr++;
    check_val("t5_iar_once", iar_wr, 1);
    check_val("t5_err_sticky", err_o, 1);

    // 6. IER rewrite beats int_i; reset in the middle of the IPR read
    clear_log();
    irq_ready_i = 1'b0; rty_arm = 1'b0; stall_ipr = 1'b1;
    ier_wr_i = 1'b1; ier_dat_i = 3'b100; src_set = 3'b100;
    @(negedge clk);
    ier_wr_i = 1'b0; src_set = 3'b000;
    wait_ipr_stb(20);
    check_val("t6_rd_active", {m_stb_o, m_addr_o}, {1'b1, 3'd3});
    check_val("t6_cnt", tr_addr.size(), 1);
    check_val("t6_ier_first", tr_word(0), mk(1'b1, 3'd1, 32'h4));
    reset = 1'b1;
    @(negedge clk);
    check_val("t6_rst_stb", m_stb_o, 0);
    @(negedge clk);
    clear_log();
    stall_ipr = 1'b0;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_val("t6_init_cnt", tr_addr.size(), 2);
    check_val("t6_init_ier", tr_word(0), mk(1'b1, 3'd1, 32'h7));
    check_val("t6_init_mer", tr_word(1), mk(1'b1, 3'd0, 32'h3));
    check_val("t6_err_clr", err_o, 0);

    check_val("sel_cyc_rules", sel_bad, 0);
    check_val("id_zero_idle", id_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
